// File: rtl/mm_sequencer_if.sv
// rtl/mm_sequencer_if.sv - control/handshake bundle between the matrix-multiply sequencer and its datapath
interface mm_sequencer_if #(
    parameter int AW = 4
);
    logic          start;
    logic          abort;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic          rd_en;
    logic          mac_clr;
    logic          mac_en;
    logic [AW-1:0] c_addr;
    logic          c_we;
    logic          busy;
    logic          done;

    // sequencer side: takes commands, drives memory/MAC strobes and status
    modport master (
        input  start, abort,
        output a_addr, b_addr, rd_en, mac_clr, mac_en, c_addr, c_we, busy, done
    );

    // datapath/host side
    modport slave (
        output start, abort,
        input  a_addr, b_addr, rd_en, mac_clr, mac_en, c_addr, c_we, busy, done
    );
endinterface

// File: rtl/mm_sequencer.sv
// rtl/mm_sequencer.sv - address/strobe sequencer for an N x N matrix multiply C = A x B
module mm_sequencer #(
    parameter int N  = 3,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    mm_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [AW-1:0] NW   = AW'(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] i, j, k;
    logic [AW-1:0] i_nxt, j_nxt, k_nxt;
    logic          mac_en_q;

    logic [AW-1:0] a_addr_c, b_addr_c, c_addr_c;
    logic          rd_en_c, mac_clr_c, c_we_c, busy_c, done_c;

    // state and index registers; reset cancels any run in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
        end else begin
            state <= state_nxt;
            i     <= i_nxt;
            j     <= j_nxt;
            k     <= k_nxt;
        end
    end

    // next state and index advance; abort overrides every transition
    always_comb begin
        state_nxt = state;
        i_nxt     = i;
        j_nxt     = j;
        k_nxt     = k;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = CLEAR;
                    i_nxt     = '0;
                    j_nxt     = '0;
                end
            end
            CLEAR: begin
                state_nxt = READ;
                k_nxt     = '0;
            end
            READ: begin
                if (k == LAST) begin
                    state_nxt = DRAIN;
                    k_nxt     = '0;
                end else begin
                    k_nxt = k + 1'b1;
                end
            end
            DRAIN: state_nxt = WRITE;
            WRITE: begin
                if (i == LAST && j == LAST) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = CLEAR;
                    if (j == LAST) begin
                        j_nxt = '0;
                        i_nxt = i + 1'b1;
                    end else begin
                        j_nxt = j + 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                i_nxt     = '0;
                j_nxt     = '0;
                k_nxt     = '0;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.abort && state != IDLE) begin
            state_nxt = IDLE;
            i_nxt     = '0;
            j_nxt     = '0;
            k_nxt     = '0;
        end
    end

    // strobe/status decode from registered state; addresses held at 0 while their strobe is low
    always_comb begin
        a_addr_c  = '0;
        b_addr_c  = '0;
        c_addr_c  = '0;
        rd_en_c   = 1'b0;
        mac_clr_c = 1'b0;
        c_we_c    = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            CLEAR: begin
                mac_clr_c = 1'b1;
                busy_c    = 1'b1;
            end
            READ: begin
                rd_en_c  = 1'b1;
                a_addr_c = i * NW + k;
                b_addr_c = k * NW + j;
                busy_c   = 1'b1;
            end
            DRAIN: busy_c = 1'b1;
            WRITE: begin
                c_we_c   = 1'b1;
                c_addr_c = i * NW + j;
                busy_c   = 1'b1;
            end
            DONE: done_c = 1'b1;
            default: ;
        endcase
    end

    // mac_en follows rd_en by the one-cycle memory read latency; an abort kills the trailing beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mac_en_q <= 1'b0;
        end else begin
            mac_en_q <= (state == READ) && !bus.abort;
        end
    end

    assign bus.a_addr  = a_addr_c;
    assign bus.b_addr  = b_addr_c;
    assign bus.c_addr  = c_addr_c;
    assign bus.rd_en   = rd_en_c;
    assign bus.mac_clr = mac_clr_c;
    assign bus.mac_en  = mac_en_q;
    assign bus.c_we    = c_we_c;
    assign bus.busy    = busy_c;
    assign bus.done    = done_c;

endmodule

// File: tb/tb_mm_sequencer.sv
// tb/tb_mm_sequencer.sv - directed self-checking bench for mm_sequencer with memory and MAC model
module tb_mm_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mm_sequencer_if #(.AW(4)) bus();

    mm_sequencer #(.N(3), .AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // memories and behavioural MAC; evaluated mid-cycle, acting as the end-of-cycle edge
    int ma [9];
    int mb [9];
    int mc [9];
    int ra, rb, acc;

    always @(negedge clk) begin
        if (reset) begin
            if (bus.c_we && bus.c_addr < 9) mc[bus.c_addr] = acc;
            if (bus.mac_clr)     acc = 0;
            else if (bus.mac_en) acc = acc + ra * rb;
            if (bus.rd_en && bus.a_addr < 9 && bus.b_addr < 9) begin
                ra = ma[bus.a_addr];
                rb = mb[bus.b_addr];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".busy"},    bus.busy,    0);
        check({tag, ".done"},    bus.done,    0);
        check({tag, ".rd_en"},   bus.rd_en,   0);
        check({tag, ".mac_clr"}, bus.mac_clr, 0);
        check({tag, ".mac_en"},  bus.mac_en,  0);
        check({tag, ".c_we"},    bus.c_we,    0);
        check({tag, ".a_addr"},  bus.a_addr,  0);
        check({tag, ".b_addr"},  bus.b_addr,  0);
        check({tag, ".c_addr"},  bus.c_addr,  0);
    endtask

    // expected outputs of cycle n of a run (cycle 0 = start sampled): CLEAR,READ x3,DRAIN,WRITE per element
    task automatic cyc_check(input int n);
        int e, p, ii, jj, kk;
        logic rd, me, mcl, we, by, dn;
        int ea, eb, ec;
        rd = 0; me = 0; mcl = 0; we = 0; ea = 0; eb = 0; ec = 0;
        by = (n >= 1 && n <= 54);
        dn = (n == 55);
        if (by) begin
            e  = (n - 1) / 6;
            p  = (n - 1) % 6;
            ii = e / 3;
            jj = e % 3;
            kk = p - 1;
            mcl = (p == 0);
            rd  = (p >= 1 && p <= 3);
            me  = (p >= 2 && p <= 4);
            we  = (p == 5);
            if (rd) begin
                ea = ii * 3 + kk;
                eb = kk * 3 + jj;
            end
            if (we) ec = e;
        end
        check($sformatf("c%0d.busy", n),    bus.busy,    by);
        check($sformatf("c%0d.done", n),    bus.done,    dn);
        check($sformatf("c%0d.mac_clr", n), bus.mac_clr, mcl);
        check($sformatf("c%0d.rd_en", n),   bus.rd_en,   rd);
        check($sformatf("c%0d.mac_en", n),  bus.mac_en,  me);
        check($sformatf("c%0d.c_we", n),    bus.c_we,    we);
        check($sformatf("c%0d.a_addr", n),  bus.a_addr,  ea);
        check($sformatf("c%0d.b_addr", n),  bus.b_addr,  eb);
        check($sformatf("c%0d.c_addr", n),  bus.c_addr,  ec);
        // hand-picked points for element (1,2)
        if (n == 31) check("e12.clr", bus.mac_clr, 1);
        if (n == 32) begin check("e12.a0", bus.a_addr, 3); check("e12.b0", bus.b_addr, 2); end
        if (n == 33) begin check("e12.a1", bus.a_addr, 4); check("e12.b1", bus.b_addr, 5); end
        if (n == 34) begin check("e12.a2", bus.a_addr, 5); check("e12.b2", bus.b_addr, 8); end
        if (n == 35) begin check("e12.mac", bus.mac_en, 1); check("e12.rd", bus.rd_en, 0); end
        if (n == 36) begin check("e12.we", bus.c_we, 1); check("e12.ca", bus.c_addr, 5); end
    endtask

    int cnt;
    int act;

    initial begin
        for (int x = 0; x < 9; x++) begin
            ma[x] = (x % 4 == 0) ? 1 : 0;   // identity: diagonal at 0,4,8
            mb[x] = x + 1;
            mc[x] = 0;
        end
        ra = 0; rb = 0; acc = 0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_quiet("rst");
        reset = 1'b1;
        repeat (3) step();
        check("idle.busy", bus.busy, 0);

        // full run with a one-cycle start
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int n = 1; n <= 58; n++) begin
            if (n > 1) step();
            cyc_check(n);
        end
        for (int x = 0; x < 9; x++) check($sformatf("cmem%0d", x), mc[x], x + 1);

        // start held high: relaunch at cycle 57, no extra writes during busy
        bus.start = 1'b1;
        step();
        cnt = 0;
        for (int n = 1; n <= 57; n++) begin
            if (n > 1) step();
            if (bus.c_we) cnt++;
            if (n == 1)  check("hold.busy1", bus.busy, 1);
            if (n == 55) check("hold.done55", bus.done, 1);
            if (n == 56) check("hold.busy56", bus.busy, 0);
            if (n == 57) check("hold.busy57", bus.busy, 1);
        end
        check("hold.we_count", cnt, 9);
        bus.start = 1'b0;
        bus.abort = 1'b1;
        step();
        check("hold.abort_busy", bus.busy, 0);
        bus.abort = 1'b0;
        step();

        // abort in cycle 15
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cnt = 0;
        for (int n = 1; n <= 15; n++) begin
            if (n > 1) step();
            if (bus.c_we) cnt++;
        end
        check("abort.rd15", bus.rd_en, 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check_quiet("abort16");
        check("abort.we_before", cnt, 2);
        act = 0;
        for (int n = 0; n < 60; n++) begin
            step();
            if (bus.c_we || bus.done || bus.busy) act++;
        end
        check("abort.quiet_after", act, 0);

        // abort together with start in IDLE is ignored: run begins
        bus.start = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("idle_abort.clr", bus.mac_clr, 1);
        check("idle_abort.busy", bus.busy, 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("idle_abort.cancel", bus.busy, 0);
        step();

        // reset mid-READ at cycle 20, no resume afterwards
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int n = 2; n <= 20; n++) step();
        check("rst20.rd_en", bus.rd_en, 1);
        check("rst20.a_addr", bus.a_addr, 3);
        reset = 1'b0;
        #1;
        check_quiet("rst20");
        #2;
        reset = 1'b1;
        act = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (bus.busy || bus.rd_en || bus.c_we || bus.mac_en || bus.done || bus.mac_clr) act++;
        end
        check("rst20.no_resume", act, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
